// File: rtl/spwm_pkg.sv
// Shared types and defaults for the sine-PWM gate driver and its carrier counter.
package spwm_pkg;

    localparam int SPWM_WIDTH    = 6;
    localparam int SPWM_CNT_MAX  = 41;
    localparam int SPWM_DEADTIME = 3;
    localparam int SPWM_DT_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DT_TO_LO,
        ST_LO,
        ST_DT_TO_HI,
        ST_HI
    } dt_state_e;

endpackage

// File: rtl/spwm_deadtime_fsm.sv
// Complementary gate sequencer: turns the raw PWM level into a hi/lo gate pair
// separated by DEADTIME cycles of both-off.
module spwm_deadtime_fsm
    import spwm_pkg::*;
#(
    parameter int DEADTIME = SPWM_DEADTIME,
    parameter int DT_WIDTH = SPWM_DT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_q,
    output logic out_hi,
    output logic out_lo
);

    localparam logic [DT_WIDTH-1:0] DT_LOAD = DT_WIDTH'(DEADTIME - 1);
    localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1);

    dt_state_e           state_q, state_d;
    logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
    logic                out_hi_q, out_lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_OFF;
            dt_cnt_q <= '0;
            out_hi_q <= 1'b0;
            out_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            // Gates decode the next state so they switch on the same edge as the FSM.
            out_hi_q <= (state_d == ST_HI);
            out_lo_q <= (state_d == ST_LO);
        end
    end

    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        case (state_q)
            ST_OFF: begin
                state_d  = raw_q ? ST_DT_TO_HI : ST_DT_TO_LO;
                dt_cnt_d = DT_LOAD;
            end
            ST_DT_TO_LO: begin
                if (dt_cnt_q != '0) begin
                    dt_cnt_d = dt_cnt_q - DT_ONE;
                end else begin
                    // Both gates are already off, so landing on the other side is safe.
                    state_d = raw_q ? ST_HI : ST_LO;
                end
            end
            ST_LO: begin
                if (raw_q) begin
                    state_d  = ST_DT_TO_HI;
                    dt_cnt_d = DT_LOAD;
                end
            end
            ST_DT_TO_HI: begin
                if (dt_cnt_q != '0) begin
                    dt_cnt_d = dt_cnt_q - DT_ONE;
                end else begin
                    state_d = raw_q ? ST_HI : ST_LO;
                end
            end
            ST_HI: begin
                if (!raw_q) begin
                    state_d  = ST_DT_TO_LO;
                    dt_cnt_d = DT_LOAD;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    assign out_hi = out_hi_q;
    assign out_lo = out_lo_q;

endmodule

// File: rtl/spwm_gate_driver.sv
// One inverter leg: double-buffered duty sample committed at the carrier valley,
// carrier compare, and dead-time gate generation.
module spwm_gate_driver
    import spwm_pkg::*;
#(
    parameter int WIDTH    = SPWM_WIDTH,
    parameter int CNT_MAX  = SPWM_CNT_MAX,
    parameter int DEADTIME = SPWM_DEADTIME,
    parameter int DT_WIDTH = SPWM_DT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [WIDTH-1:0] cnt,
    input  logic             carry_up,
    input  logic             carry_down,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             sample_ready,
    output logic             out_hi,
    output logic             out_lo,
    output logic             period_start,
    output logic             underrun
);

    localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(CNT_MAX + 1);
    localparam logic [WIDTH-1:0] CNT_PEAK = WIDTH'(CNT_MAX);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             shadow_full_q, shadow_full_d;
    logic             raw_q, raw_d;
    logic             period_start_q, underrun_q;
    logic             transfer;
    logic [WIDTH-1:0] sample_clamped;

    // Handshake: a sample moves into the shadow on any cycle with
    // sample_valid && sample_ready; the producer holds it otherwise.
    assign sample_ready   = !shadow_full_q;
    assign transfer       = sample_valid && sample_ready;
    assign sample_clamped = (sample > DUTY_MAX) ? DUTY_MAX : sample;
    assign raw_d          = (cnt < duty_q);

    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        duty_d        = duty_q;
        if (carry_down && shadow_full_q) begin
            duty_d        = shadow_q;
            shadow_full_d = 1'b0;
        end
        // Only possible with the shadow empty; a valley-cycle transfer waits for the next valley.
        if (transfer) begin
            shadow_d      = sample_clamped;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            duty_q         <= '0;
            raw_q          <= 1'b0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            duty_q         <= duty_d;
            raw_q          <= raw_d;
            period_start_q <= carry_down;
            underrun_q     <= carry_down && !shadow_full_q;
        end
    end

    spwm_deadtime_fsm #(
        .DEADTIME (DEADTIME),
        .DT_WIDTH (DT_WIDTH)
    ) u_deadtime (
        .clk    (clk),
        .rst    (rst),
        .raw_q  (raw_q),
        .out_hi (out_hi),
        .out_lo (out_lo)
    );

    assign period_start = period_start_q;
    assign underrun     = underrun_q;

    // The peak flag carries no function here; it only cross-checks the counter.
    a_carry_up_at_peak: assert property (@(posedge clk) disable iff (!rst)
        carry_up |-> (e && cnt == CNT_PEAK));
    a_carry_down_enabled: assert property (@(posedge clk) disable iff (!rst)
        carry_down |-> e);

endmodule
